// File: rtl/alu_core_if.sv
// Operand/result bundle between prealu and the ALU stage.
// Master drives operands and the start strobe; slave returns result and flags.
interface alu_core_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] ai;
    logic [WIDTH-1:0] bi;
    logic [2:0]       op;
    logic             cin;
    logic             dec;
    logic             start;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] addout;
    logic             cout;
    logic             vout;
    logic             hcout;
    logic             zout;
    logic             nout;

    modport master (
        output ai, bi, op, cin, dec, start,
        input  busy, valid, addout, cout, vout, hcout, zout, nout
    );

    modport slave (
        input  ai, bi, op, cin, dec, start,
        output busy, valid, addout, cout, vout, hcout, zout, nout
    );
endinterface

// File: rtl/alu_core.sv
// 6502 ALU stage: one op per start strobe into the ADD hold register,
// with an extra BCD correction cycle for decimal add/subtract.
module alu_core #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    alu_core_if.slave  bus
);
    localparam logic [2:0] OP_SUM  = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_EOR  = 3'd3;
    localparam logic [2:0] OP_SR   = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;
    localparam logic [2:0] OP_SL   = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DADJ = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             cin_q, cin_d;
    logic             dec_q, dec_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             bc_q, bc_d;
    logic             bhc_q, bhc_d;
    logic [WIDTH-1:0] addout_q, addout_d;
    logic             cout_q, cout_d;
    logic             vout_q, vout_d;
    logic             hcout_q, hcout_d;
    logic             zout_q, zout_d;
    logic             nout_q, nout_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] bop;
    logic [WIDTH:0]   sum;
    logic [4:0]       lo_sum;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;
    logic             res_h;
    logic             arith;
    logic [WIDTH-1:0] dadj_lo;
    logic [WIDTH-1:0] dadj_res;
    logic             dadj_c;

    // Shared adder; SUB is A + ~B + cin
    always_comb begin
        bop    = (op_q == OP_SUB) ? ~b_q : b_q;
        sum    = {1'b0, a_q} + {1'b0, bop} + {{WIDTH{1'b0}}, cin_q};
        lo_sum = {1'b0, a_q[3:0]} + {1'b0, bop[3:0]} + {4'd0, cin_q};
        arith  = (op_q == OP_SUM) || (op_q == OP_SUB);
    end

    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        res_h = 1'b0;
        unique case (op_q)
            OP_SUM, OP_SUB: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_h = lo_sum[4];
                res_v = (a_q[WIDTH-1] == bop[WIDTH-1])
                     && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  res = a_q & b_q;
            OP_OR:   res = a_q | b_q;
            OP_EOR:  res = a_q ^ b_q;
            OP_SR: begin
                res   = {cin_q, a_q[WIDTH-1:1]};
                res_c = a_q[0];
            end
            OP_SL: begin
                res   = {a_q[WIDTH-2:0], cin_q};
                res_c = a_q[WIDTH-1];
            end
            OP_PASS: begin
                res   = a_q;
                res_c = cin_q;
            end
            default: ;
        endcase
    end

    // BCD correction of the stored binary result
    always_comb begin
        dadj_lo  = bin_q;
        dadj_res = bin_q;
        dadj_c   = bc_q;
        if (op_q == OP_SUM) begin
            if ((bin_q[3:0] > 4'd9) || bhc_q)
                dadj_lo = bin_q + WIDTH'(8'h06);
            if ((dadj_lo[7:4] > 4'd9) || bc_q) begin
                dadj_res = dadj_lo + WIDTH'(8'h60);
                dadj_c   = 1'b1;
            end else begin
                dadj_res = dadj_lo;
                dadj_c   = 1'b0;
            end
        end else begin
            if (!bhc_q)
                dadj_lo = {bin_q[WIDTH-1:4], bin_q[3:0] - 4'd6};
            dadj_res = bc_q ? dadj_lo : dadj_lo - WIDTH'(8'h60);
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cin_d    = cin_q;
        dec_d    = dec_q;
        bin_d    = bin_q;
        bc_d     = bc_q;
        bhc_d    = bhc_q;
        addout_d = addout_q;
        cout_d   = cout_q;
        vout_d   = vout_q;
        hcout_d  = hcout_q;
        zout_d   = zout_q;
        nout_d   = nout_q;
        valid_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.ai;
                    b_d     = bus.bi;
                    op_d    = bus.op;
                    cin_d   = bus.cin;
                    dec_d   = bus.dec;
                    state_d = CALC;
                end
            end
            CALC: begin
                vout_d = res_v;
                zout_d = (res == '0);
                nout_d = res[WIDTH-1];
                if (dec_q && arith) begin
                    bin_d   = res;
                    bc_d    = res_c;
                    bhc_d   = res_h;
                    state_d = DADJ;
                end else begin
                    addout_d = res;
                    cout_d   = res_c;
                    hcout_d  = res_h;
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end
            end
            DADJ: begin
                addout_d = dadj_res;
                cout_d   = dadj_c;
                hcout_d  = bhc_q;
                valid_d  = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cin_q    <= 1'b0;
            dec_q    <= 1'b0;
            bin_q    <= '0;
            bc_q     <= 1'b0;
            bhc_q    <= 1'b0;
            addout_q <= '0;
            cout_q   <= 1'b0;
            vout_q   <= 1'b0;
            hcout_q  <= 1'b0;
            zout_q   <= 1'b0;
            nout_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cin_q    <= cin_d;
            dec_q    <= dec_d;
            bin_q    <= bin_d;
            bc_q     <= bc_d;
            bhc_q    <= bhc_d;
            addout_q <= addout_d;
            cout_q   <= cout_d;
            vout_q   <= vout_d;
            hcout_q  <= hcout_d;
            zout_q   <= zout_d;
            nout_q   <= nout_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.valid  = valid_q;
    assign bus.addout = addout_q;
    assign bus.cout   = cout_q;
    assign bus.vout   = vout_q;
    assign bus.hcout  = hcout_q;
    assign bus.zout   = zout_q;
    assign bus.nout   = nout_q;
endmodule

// File: tb/tb_alu_core.sv
// Bench for alu_core: directed vector table, handshake corner cases,
// and random ops against an arithmetic reference model.
module tb_alu_core;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    alu_core_if #(.WIDTH(8)) bus ();

    alu_core #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic       cin;
        logic       dec;
        logic [7:0] r;
        logic       c;
        logic       v;
        logic       h;
        logic       z;
        logic       n;
        int         lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic [2:0] op, input logic cin,
                                   input logic dec);
        vec_t e;
        int   ia, ib, bb, s, r, c, h, v, r2;
        ia = int'(a);
        ib = int'(b);
        c = 0; h = 0; v = 0; r = 0;
        case (op)
            3'd0, 3'd5: begin
                bb = (op == 3'd5) ? 255 - ib : ib;
                s  = ia + bb + int'(cin);
                r  = s % 256;
                c  = s / 256;
                h  = ((ia % 16) + (bb % 16) + int'(cin)) / 16;
                v  = ((ia / 128) == (bb / 128)) && ((r / 128) != (ia / 128));
            end
            3'd1: r = int'(a & b);
            3'd2: r = int'(a | b);
            3'd3: r = int'(a ^ b);
            3'd4: begin r = int'(cin) * 128 + ia / 2; c = ia % 2; end
            3'd6: begin r = (ia * 2 + int'(cin)) % 256; c = ia / 128; end
            default: begin r = ia; c = int'(cin); end
        endcase
        e.a = a; e.b = b; e.op = op; e.cin = cin; e.dec = dec;
        e.z = (r == 0);
        e.n = (r / 128) != 0;
        e.v = (v != 0);
        e.h = (h != 0);
        e.lat = 1;
        r2 = r;
        if (dec && (op == 3'd0)) begin
            e.lat = 2;
            if ((r2 % 16) > 9 || h != 0) r2 = (r2 + 6) % 256;
            if ((r2 / 16) > 9 || c != 0) begin
                r2 = (r2 + 96) % 256;
                c = 1;
            end else c = 0;
        end else if (dec && (op == 3'd5)) begin
            e.lat = 2;
            if (h == 0) r2 = (r2 / 16) * 16 + ((r2 % 16) + 10) % 16;
            if (c == 0) r2 = (r2 + 160) % 256;
        end
        e.r = 8'(r2);
        e.c = (c != 0);
        return e;
    endfunction

    task automatic run_op(input vec_t v, input string tag);
        int lat;
        int busy_cnt;
        bit seen;
        @(negedge clk);
        bus.ai = v.a; bus.bi = v.b; bus.op = v.op;
        bus.cin = v.cin; bus.dec = v.dec; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 0; busy_cnt = 0; seen = 0;
        while (!seen && lat < 8) begin
            @(negedge clk);
            lat++;
            if (bus.valid) seen = 1;
            else if (bus.busy) busy_cnt++;
        end
        chk({tag, " valid_seen"}, 32'(seen), 32'd1);
        chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'(v.lat));
        chk({tag, " busy_at_valid"}, 32'(bus.busy), 32'd0);
        chk({tag, " addout"}, 32'(bus.addout), 32'(v.r));
        chk({tag, " flags cvhzn"},
            32'({bus.cout, bus.vout, bus.hcout, bus.zout, bus.nout}),
            32'({v.c, v.v, v.h, v.z, v.n}));
        @(negedge clk);
        chk({tag, " valid_single"}, 32'(bus.valid), 32'd0);
    endtask

    vec_t tbl[13];
    vec_t rv;
    int   vcnt;

    initial begin
        total = 0; bad = 0;
        reset = 1'b1;
        bus.ai = '0; bus.bi = '0; bus.op = '0;
        bus.cin = 0; bus.dec = 0; bus.start = 0;

        //            a      b     op   c  d   r     c  v  h  z  n  lat
        tbl[0]  = '{8'h50, 8'h50, 3'd0, 0, 0, 8'hA0, 0, 1, 0, 0, 1, 1};
        tbl[1]  = '{8'h58, 8'h46, 3'd0, 1, 1, 8'h05, 1, 1, 0, 0, 1, 2};
        tbl[2]  = '{8'h00, 8'h01, 3'd5, 1, 0, 8'hFF, 0, 0, 0, 0, 1, 1};
        tbl[3]  = '{8'h40, 8'h13, 3'd5, 1, 1, 8'h27, 1, 0, 0, 0, 0, 2};
        tbl[4]  = '{8'h81, 8'h00, 3'd4, 1, 0, 8'hC0, 1, 0, 0, 0, 1, 1};
        tbl[5]  = '{8'hF0, 8'h0F, 3'd1, 1, 0, 8'h00, 0, 0, 0, 1, 0, 1};
        tbl[6]  = '{8'h0F, 8'hF0, 3'd2, 1, 0, 8'hFF, 0, 0, 0, 0, 1, 1};
        tbl[7]  = '{8'hAA, 8'hFF, 3'd3, 0, 0, 8'h55, 0, 0, 0, 0, 0, 1};
        tbl[8]  = '{8'h80, 8'h00, 3'd6, 0, 0, 8'h00, 1, 0, 0, 1, 0, 1};
        tbl[9]  = '{8'h7F, 8'h00, 3'd7, 1, 0, 8'h7F, 1, 0, 0, 0, 0, 1};
        tbl[10] = '{8'hFF, 8'h01, 3'd0, 0, 0, 8'h00, 1, 0, 1, 1, 0, 1};
        tbl[11] = '{8'h80, 8'h01, 3'd5, 1, 0, 8'h7F, 1, 1, 0, 0, 0, 1};
        tbl[12] = '{8'h99, 8'h01, 3'd0, 0, 1, 8'h00, 1, 0, 0, 0, 1, 2};

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        vcnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.valid) vcnt++;
        end
        chk("reset outputs",
            32'({bus.addout, bus.cout, bus.vout, bus.hcout,
                 bus.zout, bus.nout, bus.busy}), 32'd0);
        chk("reset no valid", 32'(vcnt), 32'd0);

        for (int i = 0; i < 13; i++)
            run_op(tbl[i], $sformatf("vec%0d", i));

        // start while busy must be ignored
        @(negedge clk);
        bus.ai = 8'h81; bus.op = 3'd4; bus.cin = 1; bus.dec = 0;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.ai = 8'hFF;
        vcnt = 0;
        @(negedge clk);
        bus.start = 1'b0;
        if (bus.valid) vcnt++;
        chk("busy_ignore addout", 32'(bus.addout), 32'hC0);
        chk("busy_ignore cout", 32'(bus.cout), 32'd1);
        repeat (4) begin
            @(negedge clk);
            if (bus.valid) vcnt++;
        end
        chk("busy_ignore one valid", 32'(vcnt), 32'd1);
        chk("busy_ignore held", 32'(bus.addout), 32'hC0);

        // reset during DADJ
        @(negedge clk);
        bus.ai = 8'h58; bus.bi = 8'h46; bus.op = 3'd0;
        bus.cin = 1; bus.dec = 1; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("dadj busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid reset outputs",
            32'({bus.addout, bus.cout, bus.vout, bus.hcout,
                 bus.zout, bus.nout, bus.busy, bus.valid}), 32'd0);
        vcnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.valid) vcnt++;
        end
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.valid) vcnt++;
        end
        chk("mid reset no valid", 32'(vcnt), 32'd0);
        run_op(tbl[1], "after_reset");

        for (int i = 0; i < 200; i++) begin
            rv = model(8'($urandom), 8'($urandom), 3'($urandom),
                       1'($urandom), 1'($urandom));
            run_op(rv, $sformatf("rnd%0d op%0d", i, rv.op));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
